// File: rtl/psram_define.sv
// Shared types and constants for the PSRAM command arbiter: FSM states,
// source indices and the one-hot to index helper.
package psram_cmd_arb_pkg;

  localparam int NUM_SRC = 3;

  localparam logic [1:0] SRC_APB = 2'd0;
  localparam logic [1:0] SRC_WR  = 2'd1;
  localparam logic [1:0] SRC_RD  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GAP   = 2'd3
  } arb_state_e;

  function automatic logic [1:0] onehot_to_idx(input logic [NUM_SRC-1:0] oh);
    logic [1:0] idx;
    case (oh)
      3'b010:  idx = SRC_WR;
      3'b100:  idx = SRC_RD;
      default: idx = SRC_APB;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/psram_rr_sel.sv
// Combinational winner selection: round-robin from the source after ptr_i,
// or fixed priority APB > write > read when mode_i is 0.
module psram_rr_sel
  import psram_cmd_arb_pkg::*;
(
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [1:0]         ptr_i,
  input  logic               mode_i,
  output logic [NUM_SRC-1:0] gnt_oh_o
);

  function automatic logic [NUM_SRC-1:0] pick(input logic [NUM_SRC-1:0] req,
                                              input logic [1:0] p0,
                                              input logic [1:0] p1,
                                              input logic [1:0] p2);
    logic [NUM_SRC-1:0] oh;
    oh = 3'b000;
    if (req[p0]) begin
      oh[p0] = 1'b1;
    end else if (req[p1]) begin
      oh[p1] = 1'b1;
    end else if (req[p2]) begin
      oh[p2] = 1'b1;
    end else begin
      oh = 3'b000;
    end
    return oh;
  endfunction

  // Search order rotates so the source after the last grant is tried first.
  always_comb begin
    gnt_oh_o = 3'b000;
    if (mode_i) begin
      case (ptr_i)
        SRC_APB: gnt_oh_o = pick(req_i, SRC_WR, SRC_RD, SRC_APB);
        SRC_WR:  gnt_oh_o = pick(req_i, SRC_RD, SRC_APB, SRC_WR);
        default: gnt_oh_o = pick(req_i, SRC_APB, SRC_WR, SRC_RD);
      endcase
    end else begin
      gnt_oh_o = pick(req_i, SRC_APB, SRC_WR, SRC_RD);
    end
  end

endmodule

// File: rtl/psram_cmd_arb.sv
// Arbitrates APB, AXI-write and AXI-read requests onto one PSRAM command
// channel, holding the grant until the engine reports CE# release.
module psram_cmd_arb
  import psram_cmd_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 23,
  parameter int LEN_WIDTH  = 8,
  parameter int GAP_WIDTH  = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic [NUM_SRC-1:0]           req_i,
  input  logic [NUM_SRC*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_SRC*LEN_WIDTH-1:0]  req_len_i,
  input  logic [NUM_SRC-1:0]           req_wr_i,
  output logic [NUM_SRC-1:0]           gnt_o,
  output logic                         cmd_valid_o,
  input  logic                         cmd_ready_i,
  output logic [ADDR_WIDTH-1:0]        cmd_addr_o,
  output logic [LEN_WIDTH-1:0]         cmd_len_o,
  output logic                         cmd_wr_o,
  output logic [1:0]                   cmd_src_o,
  input  logic                         done_i,
  input  logic                         cfg_rr_i,
  input  logic [GAP_WIDTH-1:0]         cfg_gap_i,
  output logic                         busy_o
);

  localparam logic [GAP_WIDTH-1:0] GAP_ZERO = {GAP_WIDTH{1'b0}};
  localparam logic [GAP_WIDTH-1:0] GAP_ONE  = {{(GAP_WIDTH-1){1'b0}}, 1'b1};

  arb_state_e              state_q, state_d;
  logic [NUM_SRC-1:0]      gnt_q, gnt_d;
  logic                    cmd_valid_q, cmd_valid_d;
  logic [ADDR_WIDTH-1:0]   cmd_addr_q, cmd_addr_d;
  logic [LEN_WIDTH-1:0]    cmd_len_q, cmd_len_d;
  logic                    cmd_wr_q, cmd_wr_d;
  logic [1:0]              cmd_src_q, cmd_src_d;
  logic                    busy_q, busy_d;
  logic [GAP_WIDTH-1:0]    gap_cnt_q, gap_cnt_d;
  logic [1:0]              ptr_q, ptr_d;

  logic [NUM_SRC-1:0]      sel_oh;
  logic [1:0]              sel_idx;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [LEN_WIDTH-1:0]    sel_len;

  psram_rr_sel u_sel (
    .req_i    (req_i),
    .ptr_i    (ptr_q),
    .mode_i   (cfg_rr_i),
    .gnt_oh_o (sel_oh)
  );

  assign sel_idx = onehot_to_idx(sel_oh);

  // Unpack the command fields of the selected source.
  always_comb begin
    case (sel_idx)
      SRC_WR: begin
        sel_addr = req_addr_i[ADDR_WIDTH +: ADDR_WIDTH];
        sel_len  = req_len_i[LEN_WIDTH +: LEN_WIDTH];
      end
      SRC_RD: begin
        sel_addr = req_addr_i[2*ADDR_WIDTH +: ADDR_WIDTH];
        sel_len  = req_len_i[2*LEN_WIDTH +: LEN_WIDTH];
      end
      default: begin
        sel_addr = req_addr_i[0 +: ADDR_WIDTH];
        sel_len  = req_len_i[0 +: LEN_WIDTH];
      end
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    cmd_valid_d = cmd_valid_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_len_d   = cmd_len_q;
    cmd_wr_d    = cmd_wr_q;
    cmd_src_d   = cmd_src_q;
    gap_cnt_d   = gap_cnt_q;
    ptr_d       = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (|req_i) begin
          state_d     = ST_ISSUE;
          gnt_d       = sel_oh;
          cmd_valid_d = 1'b1;
          cmd_addr_d  = sel_addr;
          cmd_len_d   = sel_len;
          cmd_wr_d    = req_wr_i[sel_idx];
          cmd_src_d   = sel_idx;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // done_i here (even on the handshake cycle) is not a completion.
        if (cmd_ready_i) begin
          state_d     = ST_WAIT;
          cmd_valid_d = 1'b0;
          ptr_d       = cmd_src_q;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (done_i) begin
          gnt_d      = 3'b000;
          cmd_addr_d = {ADDR_WIDTH{1'b0}};
          cmd_len_d  = {LEN_WIDTH{1'b0}};
          cmd_wr_d   = 1'b0;
          cmd_src_d  = 2'd0;
          if (cfg_gap_i == GAP_ZERO) begin
            state_d = ST_IDLE;
          end else begin
            state_d   = ST_GAP;
            gap_cnt_d = cfg_gap_i - GAP_ONE;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_ZERO) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_ONE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        gnt_d       = 3'b000;
        cmd_valid_d = 1'b0;
        gap_cnt_d   = GAP_ZERO;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      gnt_q       <= 3'b000;
      cmd_valid_q <= 1'b0;
      cmd_addr_q  <= {ADDR_WIDTH{1'b0}};
      cmd_len_q   <= {LEN_WIDTH{1'b0}};
      cmd_wr_q    <= 1'b0;
      cmd_src_q   <= 2'd0;
      busy_q      <= 1'b0;
      gap_cnt_q   <= GAP_ZERO;
      ptr_q       <= SRC_RD;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_len_q   <= cmd_len_d;
      cmd_wr_q    <= cmd_wr_d;
      cmd_src_q   <= cmd_src_d;
      busy_q      <= busy_d;
      gap_cnt_q   <= gap_cnt_d;
      ptr_q       <= ptr_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign cmd_valid_o = cmd_valid_q;
  assign cmd_addr_o  = cmd_addr_q;
  assign cmd_len_o   = cmd_len_q;
  assign cmd_wr_o    = cmd_wr_q;
  assign cmd_src_o   = cmd_src_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_psram_cmd_arb.sv
// Randomized self-checking bench for psram_cmd_arb against a transaction-level
// arbitration model.
module tb_psram_cmd_arb;

  localparam int AW = 23;
  localparam int LW = 8;
  localparam int GW = 4;

  logic            clk_i = 1'b0;
  logic            rst_n_i;
  logic [2:0]      req_i;
  logic [3*AW-1:0] req_addr_i;
  logic [3*LW-1:0] req_len_i;
  logic [2:0]      req_wr_i;
  logic [2:0]      gnt_o;
  logic            cmd_valid_o;
  logic            cmd_ready_i;
  logic [AW-1:0]   cmd_addr_o;
  logic [LW-1:0]   cmd_len_o;
  logic            cmd_wr_o;
  logic [1:0]      cmd_src_o;
  logic            done_i;
  logic            cfg_rr_i;
  logic [GW-1:0]   cfg_gap_i;
  logic            busy_o;

  logic [AW-1:0] addr_tab [3];
  logic [LW-1:0] len_tab  [3];
  logic [2:0]    wr_tab;

  int n_tests = 0;
  int n_fail  = 0;
  int last_src;

  assign req_addr_i = {addr_tab[2], addr_tab[1], addr_tab[0]};
  assign req_len_i  = {len_tab[2], len_tab[1], len_tab[0]};
  assign req_wr_i   = wr_tab;

  always #5 clk_i = ~clk_i;

  psram_cmd_arb dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .req_i       (req_i),
    .req_addr_i  (req_addr_i),
    .req_len_i   (req_len_i),
    .req_wr_i    (req_wr_i),
    .gnt_o       (gnt_o),
    .cmd_valid_o (cmd_valid_o),
    .cmd_ready_i (cmd_ready_i),
    .cmd_addr_o  (cmd_addr_o),
    .cmd_len_o   (cmd_len_o),
    .cmd_wr_o    (cmd_wr_o),
    .cmd_src_o   (cmd_src_o),
    .done_i      (done_i),
    .cfg_rr_i    (cfg_rr_i),
    .cfg_gap_i   (cfg_gap_i),
    .busy_o      (busy_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Winner per the arbitration rules: fixed APB>WR>RD, or rotate after last.
  function automatic int model_winner(input logic [2:0] req, input logic rr, input int last);
    if (!rr) begin
      for (int i = 0; i < 3; i++) if (req[i]) return i;
    end else begin
      for (int k = 1; k <= 3; k++) begin
        int c;
        c = (last + k) % 3;
        if (req[c]) return c;
      end
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic randomize_fields();
    for (int i = 0; i < 3; i++) begin
      addr_tab[i] = AW'($urandom);
      len_tab[i]  = LW'($urandom);
    end
    wr_tab = 3'($urandom);
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_ctl"}, {27'd0, busy_o, cmd_valid_o, gnt_o}, 32'd0);
    check_eq({tag, "_fld"}, {cmd_wr_o, cmd_src_o, cmd_len_o, 21'd0}, 32'd0);
    check_eq({tag, "_addr"}, 32'(cmd_addr_o), 32'd0);
  endtask

  task automatic run_txn(input logic [2:0] req, input logic rr, input logic [2:0] req_wait,
                         input logic [3:0] gap, input int bp, input int wt,
                         input logic stray, input logic keep);
    int w;
    logic [AW-1:0] e_addr;
    logic [LW-1:0] e_len;
    logic          e_wr;
    if (!keep) randomize_fields();
    cfg_rr_i = rr;
    req_i    = req;
    w = model_winner(req, rr, last_src);
    e_addr = addr_tab[w];
    e_len  = len_tab[w];
    e_wr   = wr_tab[w];
    tick();
    check_eq("issue_valid", 32'(cmd_valid_o), 32'd1);
    check_eq("issue_gnt", 32'(gnt_o), 32'd1 << w);
    check_eq("issue_src", 32'(cmd_src_o), 32'(w));
    check_eq("issue_addr", 32'(cmd_addr_o), 32'(e_addr));
    check_eq("issue_len_wr", {23'd0, cmd_wr_o, cmd_len_o}, {23'd0, e_wr, e_len});
    check_eq("issue_busy", 32'(busy_o), 32'd1);
    for (int i = 0; i < bp; i++) begin
      cmd_ready_i = 1'b0;
      done_i = 1'($urandom);
      randomize_fields();
      tick();
      check_eq("bp_valid", 32'(cmd_valid_o), 32'd1);
      check_eq("bp_addr", 32'(cmd_addr_o), 32'(e_addr));
      check_eq("bp_len_src", {22'd0, cmd_src_o, cmd_len_o}, {22'd0, 2'(w), e_len});
    end
    cmd_ready_i = 1'b1;
    done_i = stray;
    tick();
    cmd_ready_i = 1'b0;
    done_i = 1'b0;
    last_src = w;
    req_i = req_wait;
    check_eq("hs_valid", 32'(cmd_valid_o), 32'd0);
    check_eq("hs_gnt", 32'(gnt_o), 32'd1 << w);
    check_eq("hs_busy", 32'(busy_o), 32'd1);
    for (int i = 0; i < wt; i++) begin
      tick();
      check_eq("wait_gnt", 32'(gnt_o), 32'd1 << w);
      check_eq("wait_valid_busy", {30'd0, cmd_valid_o, busy_o}, 32'd1);
    end
    done_i = 1'b1;
    cfg_gap_i = gap;
    tick();
    done_i = 1'b0;
    cfg_gap_i = GW'($urandom);
    check_eq("done_gnt", 32'(gnt_o), 32'd0);
    if (gap == 4'd0) begin
      check_idle("nogap_idle");
    end else begin
      check_eq("gap_busy", 32'(busy_o), 32'd1);
      for (int i = 1; i < int'(gap); i++) begin
        done_i = 1'($urandom);
        tick();
        check_eq("gap_busy", 32'(busy_o), 32'd1);
        check_eq("gap_gnt", 32'(gnt_o), 32'd0);
      end
      done_i = 1'($urandom);
      tick();
      done_i = 1'b0;
      check_idle("gap_end_idle");
    end
  endtask

  initial begin
    rst_n_i     = 1'b0;
    req_i       = 3'b000;
    cmd_ready_i = 1'b0;
    done_i      = 1'b0;
    cfg_rr_i    = 1'b0;
    cfg_gap_i   = 4'd0;
    randomize_fields();
    last_src    = 2;
    #1;
    check_idle("reset");
    #20;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    tick();

    // Round-robin with all sources requesting: 0,1,2,0.
    for (int i = 0; i < 4; i++) run_txn(3'b111, 1'b1, 3'b111, 4'd0, 0, 1, 1'b0, 1'b0);

    // Single APB write with known fields.
    addr_tab[0] = 23'h000100;
    len_tab[0]  = 8'd3;
    wr_tab      = 3'b001;
    run_txn(3'b001, 1'b0, 3'b000, 4'd0, 0, 2, 1'b0, 1'b1);

    // Fixed priority: write wins, then APB joins during WAIT and wins next.
    run_txn(3'b110, 1'b0, 3'b111, 4'd0, 0, 2, 1'b0, 1'b0);
    run_txn(3'b111, 1'b0, 3'b111, 4'd0, 0, 1, 1'b0, 1'b0);

    run_txn(3'b100, 1'b1, 3'b000, 4'd0, 5, 1, 1'b1, 1'b0);
    run_txn(3'b011, 1'b1, 3'b000, 4'd4, 1, 0, 1'b1, 1'b0);

    req_i = 3'b000;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle("no_req_idle");
    end

    for (int n = 0; n < 40; n++) begin
      logic [2:0] r;
      r = 3'($urandom_range(1, 7));
      run_txn(r, 1'($urandom), 3'($urandom), 4'($urandom_range(0, 5)),
              int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), 1'($urandom), 1'b0);
    end

    // Reset while waiting for done_i.
    cfg_rr_i = 1'b1;
    req_i = 3'b100;
    tick();
    cmd_ready_i = 1'b1;
    tick();
    cmd_ready_i = 1'b0;
    tick();
    check_eq("pre_reset_gnt", 32'(gnt_o), 32'd4);
    rst_n_i = 1'b0;
    #1;
    check_idle("async_reset");
    tick();
    tick();
    check_idle("held_reset");
    @(negedge clk_i);
    rst_n_i = 1'b1;
    last_src = 2;
    run_txn(3'b111, 1'b1, 3'b000, 4'd2, 1, 1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/psram_cmd_arb.md
PSRAM_CMD_ARB -- requirements
Module: psram_cmd_arb

Interface
REQ-001 Parameter ADDR_WIDTH, default 23, PSRAM byte address width.
REQ-002 Parameter LEN_WIDTH, default 8, burst length field width; the value is beats minus 1.
REQ-003 Parameter GAP_WIDTH, default 4, width of the CE#-high gap counter.
REQ-004 clk_i  in  1  single clock; rst_n_i  in  1  asynchronous active-low reset.
REQ-005 req_i  in  3  request per source: bit0 APB direct access, bit1 AXI write, bit2 AXI read.
REQ-006 req_addr_i  in  3*ADDR_WIDTH  packed start address per source; req_len_i  in  3*LEN_WIDTH  packed length per source.
REQ-007 req_wr_i  in  3  write flag per source; gnt_o  out  3  one-hot grant, held for the whole transaction.
REQ-008 cmd_valid_o  out  1; cmd_ready_i  in  1; together they form the valid/ready command handshake to the PSRAM engine.
REQ-009 cmd_addr_o  out  ADDR_WIDTH; cmd_len_o  out  LEN_WIDTH; cmd_wr_o  out  1; cmd_src_o  out  2  granted source index.
REQ-010 done_i  in  1  one-cycle pulse from the engine when CE# is deasserted at the end of a transaction.
REQ-011 cfg_rr_i  in  1  1 selects round-robin, 0 selects fixed priority (APB > write > read); cfg_gap_i  in  GAP_WIDTH  minimum idle cycles between transactions.
REQ-012 busy_o  out  1  high in every state except IDLE.

Function
REQ-013 The FSM SHALL have four states: IDLE, ISSUE, WAIT, GAP.
REQ-014 In IDLE with any req_i bit set, the arbiter SHALL select a winner, register gnt_o, the command fields and cmd_src_o, and enter ISSUE on the next edge.
REQ-015 In ISSUE, cmd_valid_o SHALL be 1, and the command fields SHALL stay stable until a cycle with cmd_ready_i=1; the FSM then enters WAIT.
REQ-016 In WAIT, when done_i=1, gnt_o SHALL clear and the FSM SHALL enter GAP, or go directly to IDLE if cfg_gap_i=0.
REQ-017 GAP SHALL load a down-counter with cfg_gap_i-1 and return to IDLE when the counter reaches 0, giving exactly cfg_gap_i cycles with busy_o=1 and no grant.
REQ-018 Round-robin SHALL search starting from the source after the last granted one, wrapping 2->0; the pointer updates only on a cmd handshake; reset value points to source 2 so that source 0 is searched first.
REQ-019 Fixed priority SHALL ignore the pointer; changing cfg_rr_i takes effect at the next IDLE decision only.
REQ-020 Request-to-cmd_valid_o latency SHALL be 1 cycle from IDLE.
REQ-021 A requester dropping req_i while granted SHALL NOT abort the transaction; the grant holds until done_i.
REQ-022 done_i in IDLE, ISSUE or GAP SHALL be ignored; done_i in the same cycle as the handshake SHALL NOT be taken as completion.
REQ-023 cfg_gap_i is sampled on entry to GAP; later changes do not affect a running gap.
REQ-024 When no request is pending, the arbiter SHALL stay in IDLE with all outputs at their reset values.

Reset
REQ-025 While rst_n_i=0, the block SHALL be asynchronously forced to state IDLE, with gnt_o=0, cmd_valid_o=0, cmd_addr_o=0, cmd_len_o=0, cmd_wr_o=0, cmd_src_o=0, busy_o=0, gap counter 0, and the RR pointer at 2.
REQ-026 A reset mid-transaction SHALL discard the transaction; the engine is reset by the same rst_n_i.

Structure
REQ-027 The state enum, the source index constants (APB=0, WR=1, RD=2) and a NUM_SRC=3 localparam SHALL live in psram_define.sv.
REQ-028 The winner selection SHALL be one combinational sub-module, psram_rr_sel (inputs req, pointer, mode; output one-hot), instantiated once.
REQ-029 All outputs SHALL be registered.

Verification
REQ-030 Single request: req_i=001, addr 0x000100, len 3, wr=1, cmd_ready_i=1 -> cmd_valid_o high 1 cycle after req, cmd_src_o=0, gnt_o=001 until done_i.
REQ-031 Round-robin: req_i=111 held, cfg_rr_i=1, cfg_gap_i=0 -> grant order 0,1,2,0.
REQ-032 Fixed priority: req_i=110 then 111 during WAIT, cfg_rr_i=0 -> grant order 1,0.
REQ-033 Backpressure: cmd_ready_i low 5 cycles -> cmd_valid_o and fields stable for 6 cycles, with a single handshake.
REQ-034 Gap: cfg_gap_i=4 -> exactly 4 cycles from done_i to the next IDLE decision, busy_o=1, gnt_o=0; a stray done_i during GAP has no effect.
REQ-035 Reset mid-WAIT: rst_n_i low 2 cycles -> all outputs at reset values immediately; the first grant after reset goes to source 0.
